// File: rtl/axis_split.sv
// rtl/axis_split.sv - wide-to-narrow AXI-Stream serializer, LSB slice first
module axis_split #(
    parameter int WIDTH = 8,
    parameter int SPLIT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SPLIT*WIDTH-1:0]   s_rx_tdata,
    input  logic                     s_rx_tvalid,
    input  logic                     s_rx_tlast,
    output logic                     s_rx_tready,
    output logic [WIDTH-1:0]         m_tx_tdata,
    output logic                     m_tx_tvalid,
    output logic                     m_tx_tlast,
    input  logic                     m_tx_tready
);

    localparam int IW = (SPLIT > 1) ? $clog2(SPLIT) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(SPLIT - 1);

    logic [SPLIT*WIDTH-1:0] data_r;
    logic                   last_r;
    logic                   valid_r;
    logic [IW-1:0]          idx;
    logic                   on_last;
    logic                   load;
    logic                   beat_done;

    assign on_last     = (idx == LAST_IDX);
    // A new word may enter in the same cycle the final beat of the current one drains.
    assign s_rx_tready = !rst && (!valid_r || (m_tx_tready && on_last));
    assign load        = s_rx_tvalid && s_rx_tready;
    assign beat_done   = valid_r && m_tx_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            idx     <= '0;
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            idx     <= '0;
            last_r  <= s_rx_tlast;
        end else if (beat_done) begin
            if (on_last) begin
                valid_r <= 1'b0;
                idx     <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // The hold register needs no reset: its contents are only observed behind valid_r.
    always_ff @(posedge clk) begin
        if (load) begin
            data_r <= s_rx_tdata;
        end
    end

    generate
        if (SPLIT == 1) begin : g_single
            assign m_tx_tdata = data_r;
        end else begin : g_multi
            logic [WIDTH-1:0] beats [SPLIT];
            for (genvar k = 0; k < SPLIT; k++) begin : g_beat
                assign beats[k] = data_r[WIDTH*k +: WIDTH];
            end
            assign m_tx_tdata = beats[idx];
        end
    endgenerate

    assign m_tx_tvalid = valid_r;
    assign m_tx_tlast  = last_r && on_last;

endmodule

// File: tb/tb_axis_split.sv
// tb/tb_axis_split.sv - bench for axis_split at SPLIT=2, SPLIT=4 and SPLIT=1
module tb_axis_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_bc;

    logic [15:0] a_sd;
    logic        a_sv, a_sl, a_sr;
    logic [7:0]  a_md;
    logic        a_mv, a_ml, a_mr;

    logic [31:0] b_sd;
    logic        b_sv, b_sl, b_sr;
    logic [7:0]  b_md;
    logic        b_mv, b_ml, b_mr;

    logic [15:0] c_sd;
    logic        c_sv, c_sl, c_sr;
    logic [15:0] c_md;
    logic        c_mv, c_ml, c_mr;

    axis_split #(.WIDTH(8), .SPLIT(2)) dut_a (
        .clk(clk), .rst(rst_a),
        .s_rx_tdata(a_sd), .s_rx_tvalid(a_sv), .s_rx_tlast(a_sl), .s_rx_tready(a_sr),
        .m_tx_tdata(a_md), .m_tx_tvalid(a_mv), .m_tx_tlast(a_ml), .m_tx_tready(a_mr)
    );

    axis_split #(.WIDTH(8), .SPLIT(4)) dut_b (
        .clk(clk), .rst(rst_bc),
        .s_rx_tdata(b_sd), .s_rx_tvalid(b_sv), .s_rx_tlast(b_sl), .s_rx_tready(b_sr),
        .m_tx_tdata(b_md), .m_tx_tvalid(b_mv), .m_tx_tlast(b_ml), .m_tx_tready(b_mr)
    );

    axis_split #(.WIDTH(16), .SPLIT(1)) dut_c (
        .clk(clk), .rst(rst_bc),
        .s_rx_tdata(c_sd), .s_rx_tvalid(c_sv), .s_rx_tlast(c_sl), .s_rx_tready(c_sr),
        .m_tx_tdata(c_md), .m_tx_tvalid(c_mv), .m_tx_tlast(c_ml), .m_tx_tready(c_mr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    int         wi;
    int         nsent, nrecv;
    bit         fired, stalled;
    logic [7:0] hold_d;
    logic       hold_l;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    initial begin
        rst_a  = 1'b1;
        rst_bc = 1'b1;
        a_sd = '0; a_sv = 0; a_sl = 0; a_mr = 0;
        b_sd = '0; b_sv = 0; b_sl = 0; b_mr = 0;
        c_sd = '0; c_sv = 0; c_sl = 0; c_mr = 0;
        repeat (3) cyc();

        mid();
        check("rst_a_sready", 64'(a_sr), 64'd0);
        check("rst_a_valid",  64'(a_mv), 64'd0);
        check("rst_a_last",   64'(a_ml), 64'd0);
        check("rst_b_valid",  64'(b_mv), 64'd0);
        check("rst_c_sready", 64'(c_sr), 64'd0);
        cyc();
        rst_a  = 1'b0;
        rst_bc = 1'b0;
        mid();
        check("post_rst_a_sready", 64'(a_sr), 64'd1);
        check("post_rst_c_sready", 64'(c_sr), 64'd1);

        // single word with tlast, beats EF then BE
        cyc();
        a_sd = 16'hBEEF; a_sv = 1; a_sl = 1; a_mr = 1;
        mid();
        check("t1_sready", 64'(a_sr), 64'd1);
        cyc();
        a_sv = 0;
        mid();
        check("t1_b0_valid", 64'(a_mv), 64'd1);
        check("t1_b0_data",  64'(a_md), 64'hEF);
        check("t1_b0_last",  64'(a_ml), 64'd0);
        cyc();
        mid();
        check("t1_b1_valid", 64'(a_mv), 64'd1);
        check("t1_b1_data",  64'(a_md), 64'hBE);
        check("t1_b1_last",  64'(a_ml), 64'd1);
        cyc();
        mid();
        check("t1_idle", 64'(a_mv), 64'd0);

        // back-to-back words, no valid gap
        cyc();
        wi = 0;
        a_sd = 16'h0100; a_sv = 1; a_sl = 0; a_mr = 1;
        for (int c = 0; c <= 8; c++) begin
            mid();
            check("t2_sready", 64'(a_sr), 64'(c % 2 == 0));
            check("t2_valid",  64'(a_mv), 64'(c >= 1));
            if (c >= 1) check("t2_data", 64'(a_md), 64'(c - 1));
            cyc();
            if (c % 2 == 0 && wi < 4) begin
                wi++;
                if (wi == 4) a_sv = 0;
                else a_sd = {8'(2 * wi + 1), 8'(2 * wi)};
            end
        end
        mid();
        check("t2_idle", 64'(a_mv), 64'd0);

        // backpressure holds beat 0
        cyc();
        a_sd = 16'hA55A; a_sv = 1; a_sl = 0; a_mr = 1;
        mid();
        check("t3_sready", 64'(a_sr), 64'd1);
        cyc();
        a_sv = 0; a_mr = 0;
        for (int s = 0; s < 3; s++) begin
            mid();
            check("t3_hold_valid",  64'(a_mv), 64'd1);
            check("t3_hold_data",   64'(a_md), 64'h5A);
            check("t3_hold_last",   64'(a_ml), 64'd0);
            check("t3_hold_sready", 64'(a_sr), 64'd0);
            cyc();
        end
        a_mr = 1;
        mid();
        check("t3_b0_data", 64'(a_md), 64'h5A);
        cyc();
        mid();
        check("t3_b1_data", 64'(a_md), 64'hA5);
        check("t3_b1_sready", 64'(a_sr), 64'd1);
        cyc();
        mid();
        check("t3_idle", 64'(a_mv), 64'd0);

        // reset mid-word drops the upper beat
        cyc();
        a_sd = 16'h1234; a_sv = 1; a_sl = 1; a_mr = 1;
        mid();
        cyc();
        a_sv = 0; rst_a = 1;
        mid();
        check("t4_b0_data", 64'(a_md), 64'h34);
        cyc();
        rst_a = 0;
        mid();
        check("t4_dropped", 64'(a_mv), 64'd0);
        check("t4_sready",  64'(a_sr), 64'd1);
        cyc();
        a_sd = 16'h5678; a_sv = 1; a_sl = 0;
        mid();
        cyc();
        a_sv = 0;
        mid();
        check("t4_n0_valid", 64'(a_mv), 64'd1);
        check("t4_n0_data",  64'(a_md), 64'h78);
        cyc();
        mid();
        check("t4_n1_data", 64'(a_md), 64'h56);
        check("t4_n1_last", 64'(a_ml), 64'd0);
        cyc();
        mid();
        check("t4_idle", 64'(a_mv), 64'd0);

        // SPLIT=1 register slice with toggling ready
        cyc();
        c_sd = 16'hCAFE; c_sv = 1; c_sl = 1; c_mr = 0;
        mid();
        check("t6_sready_empty", 64'(c_sr), 64'd1);
        cyc();
        c_sv = 0;
        mid();
        check("t6_valid", 64'(c_mv), 64'd1);
        check("t6_data",  64'(c_md), 64'hCAFE);
        check("t6_sready_full", 64'(c_sr), 64'd0);
        cyc();
        c_mr = 1;
        c_sd = 16'h1357; c_sv = 1; c_sl = 0;
        mid();
        check("t6_data_held", 64'(c_md), 64'hCAFE);
        check("t6_last", 64'(c_ml), 64'd1);
        check("t6_sready_drain", 64'(c_sr), 64'd1);
        cyc();
        c_sv = 0; c_mr = 0;
        mid();
        check("t6_next_valid", 64'(c_mv), 64'd1);
        check("t6_next_data",  64'(c_md), 64'h1357);
        check("t6_next_last",  64'(c_ml), 64'd0);
        cyc();
        c_mr = 1;
        mid();
        cyc();
        mid();
        check("t6_idle", 64'(c_mv), 64'd0);

        // SPLIT=4 random traffic against a beat queue
        nsent = 0; nrecv = 0; fired = 0; stalled = 0;
        cyc();
        for (int n = 0; n < 20000 && nrecv < 4000; n++) begin
            if (!b_sv || fired) begin
                if (nsent < 1000 && $urandom_range(3) != 0) begin
                    b_sv = 1;
                    b_sd = $urandom;
                    b_sl = 1'($urandom_range(1));
                end else begin
                    b_sv = 0;
                end
            end
            b_mr = ($urandom_range(3) != 0);
            mid();
            if (stalled) begin
                check("t5_stable_data", 64'(b_md), 64'(hold_d));
                check("t5_stable_last", 64'(b_ml), 64'(hold_l));
            end
            fired = b_sv && b_sr;
            if (fired) begin
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({b_sl && (k == 3), b_sd[8*k +: 8]});
                nsent++;
            end
            if (b_mv && b_mr) begin
                if (exp_q.size() == 0) begin
                    check("t5_extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("t5_data", 64'(b_md), 64'(e[7:0]));
                    check("t5_last", 64'(b_ml), 64'(e[8]));
                end
                nrecv++;
            end
            stalled = b_mv && !b_mr;
            hold_d  = b_md;
            hold_l  = b_ml;
            cyc();
        end
        check("t5_beats", 64'(nrecv), 64'd4000);
        check("t5_leftover", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_split.md
Name: axis_split

Overview:
- Wide-to-narrow AXI-Stream serializer. The inverse of the team's narrow-to-wide packer.
- Accepts one word of SPLIT*WIDTH bits and emits it as SPLIT consecutive WIDTH-bit beats, LSB slice first.
- Sits on TX datapaths where wide internal buses feed narrower converters or links.
- Carries full AXI-Stream backpressure and a packet tlast.

Parameters:
- WIDTH, default 8: width of each output beat in bits.
- SPLIT, default 2: number of output beats per input word; must be >= 1.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  reset; synchronous, active-high.
- s_rx_tdata  input  SPLIT*WIDTH  wide input word.
- s_rx_tvalid  input  1  input word valid.
- s_rx_tlast  input  1  input word ends a packet.
- s_rx_tready  output  1  block can accept a wide word this cycle.
- m_tx_tdata  output  WIDTH  narrow output beat.
- m_tx_tvalid  output  1  output beat valid.
- m_tx_tlast  output  1  last beat of a packet.
- m_tx_tready  input  1  downstream accepts the beat.

Behaviour:
- State:
  - hold register data_r (SPLIT*WIDTH bits)
  - last_r
  - valid_r
  - beat index idx, width max(1, clog2(SPLIT))
- Reset: while rst is high, every clk edge sets valid_r=0, idx=0, last_r=0. Outputs during and after reset:
  - m_tx_tvalid=0, m_tx_tlast=0.
  - s_rx_tready is forced 0 while rst is high and rises the first cycle after rst deasserts.
  - data_r is not reset; m_tx_tdata is don't-care while m_tx_tvalid=0.
- Output mapping (all outputs driven from registers only; no combinational path from s_rx_* to m_tx_*):
  - m_tx_tvalid = valid_r.
  - m_tx_tdata = data_r[WIDTH*idx +: WIDTH].
  - m_tx_tlast = last_r AND (idx == SPLIT-1).
- Ready: s_rx_tready = !rst AND (!valid_r OR (m_tx_tready AND idx == SPLIT-1)).
  - This is a combinational path from m_tx_tready, permitted.
- Load, when s_rx_tvalid && s_rx_tready:
  - data_r <= s_rx_tdata, last_r <= s_rx_tlast, valid_r <= 1, idx <= 0.
  - Latency: a word accepted at edge N gives its first beat valid in cycle N+1.
- Advance, when m_tx_tvalid && m_tx_tready && idx != SPLIT-1: idx <= idx+1.
- Final beat, when m_tx_tvalid && m_tx_tready && idx == SPLIT-1:
  - If a load occurs the same edge, the load rule wins: no bubble.
  - Otherwise valid_r <= 0 and idx <= 0.
- Throughput: with m_tx_tready held high and input always valid, m_tx_tvalid stays high continuously. s_rx_tready pulses once every SPLIT cycles.
- Stability: while m_tx_tvalid=1 and m_tx_tready=0, m_tx_tdata, m_tx_tlast and idx hold unchanged.
- Beat order: beat k carries bits [WIDTH*k +: WIDTH]. The packer fed with this block's output reproduces the original word bit-exactly.
- tlast: asserted only on beat SPLIT-1 of a word whose s_rx_tlast was 1. Never on earlier beats.
- SPLIT=1:
  - Behaves as a single-entry register slice: idx is constant 0.
  - s_rx_tready = !valid_r OR m_tx_tready.
  - Latency is 1 cycle.
- Reset mid-word: remaining beats are discarded. The next accepted word starts at beat 0.

Test Plan:
1. WIDTH=8, SPLIT=2. Send one word 16'hBEEF with tlast=1, m_tx_tready=1 -> 8'hEF (tlast=0), then 8'hBE (tlast=1) on consecutive cycles starting 1 cycle after acceptance. m_tx_tvalid=0 afterwards.
2. Stream of 4 back-to-back words 16'h0100, 16'h0302, 16'h0504, 16'h0706, ready always high -> beats 00..07 on 8 consecutive cycles with no valid gap. s_rx_tready high on every second cycle.
3. Send 16'hA55A and hold m_tx_tready=0 for 3 cycles after the first beat presents -> m_tx_tdata stays 8'h5A with tvalid=1 and s_rx_tready=0. On release, 8'h5A then 8'hA5.
4. Assert rst for 1 cycle after beat 0 of 16'h1234 is accepted -> m_tx_tvalid=0 the next cycle and 8'h12 is never emitted. A following word 16'h5678 emits 8'h78, then 8'h56.
5. SPLIT=4, WIDTH=8, 1000 random words with random tlast, random s_rx_tvalid and random m_tx_tready; output looped into the packer (EXPAND=4) -> words and tlast bit-exact, no loss or duplication.
6. SPLIT=1, WIDTH=16: send 16'hCAFE with m_tx_tready toggling -> output 16'hCAFE one cycle after acceptance, held while ready=0. s_rx_tready=1 whenever the stage is empty or draining.
